// File: rtl/sp_ram_pkg.sv
// Shared constants for the single-port RAM with selectable read-during-write mode.
// Holds the RW_MODE encodings and the clear-sequencer state encoding.
package sp_ram_pkg;

  localparam int RW_WRITE_FIRST = 0;
  localparam int RW_READ_FIRST  = 1;
  localparam int RW_NO_CHANGE   = 2;

  typedef logic [0:0] clr_state_t;
  localparam clr_state_t CLEAR = 1'b0;
  localparam clr_state_t READY = 1'b1;

endpackage

// File: rtl/sp_ram_clear_seq.sv
// Post-reset clear sequencer: walks every word writing zero, then hands the
// array write port back to the user path.
module sp_ram_clear_seq
  import sp_ram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = 6,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usr_we,
  input  logic [BE_W-1:0]   usr_be,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic              init_busy,
  output logic              wr_en,
  output logic [BE_W-1:0]   wr_be,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam clr_state_t        RST_STATE = (CLEAR_ON_RST != 0) ? CLEAR : READY;

  clr_state_t        state_reg;
  logic [ADDR_W-1:0] clr_addr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RST_STATE;
      clr_addr_reg <= '0;
    end else if (state_reg == CLEAR) begin
      clr_addr_reg <= clr_addr_reg + 1'b1;
      if (clr_addr_reg == LAST_ADDR)
        state_reg <= READY;
    end
  end

  assign init_busy = (state_reg == CLEAR);

  // While clearing, the sequencer owns the write port outright.
  always_comb begin
    wr_en   = usr_we;
    wr_be   = usr_be;
    wr_addr = usr_addr;
    wr_data = usr_wdata;
    if (init_busy) begin
      wr_en   = 1'b1;
      wr_be   = '1;
      wr_addr = clr_addr_reg;
      wr_data = '0;
    end
  end

endmodule

// File: rtl/sp_ram_rwmode.sv
// Parametrised single-port synchronous RAM with byte-lane writes, selectable
// read-during-write behaviour, optional output register and post-reset clear.
module sp_ram_rwmode
  import sp_ram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int LANE_W       = 8,
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = 6,
  parameter int RW_MODE      = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1,
  localparam int BE_W        = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic              init_busy
);

  generate
    if (DATA_W % LANE_W != 0) begin : g_bad_lane
      $error("sp_ram_rwmode: DATA_W must be a multiple of LANE_W");
    end
    if (2**ADDR_W < DEPTH) begin : g_bad_addr
      $error("sp_ram_rwmode: ADDR_W too narrow for DEPTH");
    end
    if (RW_MODE < 0 || RW_MODE > 2) begin : g_bad_mode
      $error("sp_ram_rwmode: RW_MODE must be 0, 1 or 2");
    end
  endgenerate

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic              in_range;
  logic              wr_en;
  logic [BE_W-1:0]   wr_be;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] s1_data_reg;
  logic              s1_valid_reg;

  assign acc      = en & ~init_busy;
  assign in_range = ({1'b0, addr} < DEPTH_LIM);

  sp_ram_clear_seq #(
    .DATA_W       (DATA_W),
    .BE_W         (BE_W),
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .usr_we    (acc & we & in_range),
    .usr_be    (be),
    .usr_addr  (addr),
    .usr_wdata (wdata),
    .init_busy (init_busy),
    .wr_en     (wr_en),
    .wr_be     (wr_be),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i])
          mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
      end
    end
  end

  // Read port: s1_data_reg only changes when a result is produced, so it holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_reg  <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= 1'b0;
      if (acc && (!we || RW_MODE != RW_NO_CHANGE)) begin
        s1_valid_reg <= 1'b1;
        if (!in_range) begin
          s1_data_reg <= '0;
        end else if (we && RW_MODE == RW_WRITE_FIRST) begin
          for (int i = 0; i < BE_W; i++)
            s1_data_reg[i*LANE_W +: LANE_W] <= be[i] ? wdata[i*LANE_W +: LANE_W]
                                                     : mem[addr][i*LANE_W +: LANE_W];
        end else begin
          s1_data_reg <= mem[addr];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] s2_data_reg;
      logic              s2_valid_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_data_reg  <= '0;
          s2_valid_reg <= 1'b0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          if (s1_valid_reg)
            s2_data_reg <= s1_data_reg;
        end
      end

      assign rdata    = s2_data_reg;
      assign rd_valid = s2_valid_reg;
    end else begin : g_no_out_reg
      assign rdata    = s1_data_reg;
      assign rd_valid = s1_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_rwmode.sv
// Directed bench: four RAM instances (write-first, read-first, no-change, and a
// 48-deep registered-output write-first) share one stimulus stream.
module tb_sp_ram_rwmode;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        we;
  logic [3:0]  be;
  logic [5:0]  addr;
  logic [31:0] wdata;

  logic [31:0] rdata0, rdata1, rdata2, rdata3;
  logic        rdv0, rdv1, rdv2, rdv3;
  logic        busy0, busy1, busy2, busy3;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sp_ram_rwmode #(.RW_MODE(0)) u_wf (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .rd_valid(rdv0), .init_busy(busy0));

  sp_ram_rwmode #(.RW_MODE(1)) u_rf (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .rd_valid(rdv1), .init_busy(busy1));

  sp_ram_rwmode #(.RW_MODE(2)) u_nc (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .rd_valid(rdv2), .init_busy(busy2));

  sp_ram_rwmode #(.DEPTH(48), .OUT_REG(1)) u_d48 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .rd_valid(rdv3), .init_busy(busy3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic op(input logic w, input logic [3:0] b, input logic [5:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(posedge clk);
    #1;
    en = 1'b0;
    $display("[TB] op we=%0b be=%h addr=%0d wdata=%h -> wf=%h/%0b rf=%h/%0b nc=%h/%0b d48=%h/%0b",
             w, b, a, d, rdata0, rdv0, rdata1, rdv1, rdata2, rdv2, rdata3, rdv3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts rising edges from reset release until init_busy drops on each size.
  task automatic count_busy(output int n64, output int n48);
    n64 = 0;
    n48 = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (busy0) check("rdv_in_clear", 32'(rdv0), 32'd0);
      if (!busy3 && n48 == 0) n48 = c;
      if (!busy0 && n64 == 0) begin
        n64 = c;
        en  = 1'b0;
      end
      if (n64 != 0 && n48 != 0) break;
    end
    $display("[TB] clear done: depth64 %0d cycles, depth48 %0d cycles", n64, n48);
  endtask

  logic [5:0]  rd_addr [5] = '{6'd7, 6'd50, 6'd5, 6'd2, 6'd5};
  logic [31:0] exp_wf  [5] = '{32'hA5A5A5A5, 32'hCAFEF00D, 32'h11AD33EF, 32'h0, 32'h11AD33EF};
  logic [31:0] exp_d48 [5] = '{32'hA5A5A5A5, 32'h0, 32'h11AD33EF, 32'h0, 32'h11AD33EF};

  initial begin
    int n64, n48;
    rst = 1'b0; en = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_rdata", rdata0, 32'h0);
    check("rst_rdv", 32'(rdv0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_busy_d48", 32'(busy3), 32'd1);

    // Release reset with a write strobe pending; the clear must swallow it.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en = 1'b1; we = 1'b1; be = 4'hF; addr = 6'd63; wdata = 32'hFFFFFFFF;
    count_busy(n64, n48);
    check("clear_len_64", 32'(n64), 32'd64);
    check("clear_len_48", 32'(n48), 32'd48);
    idle(3);

    // Back-to-back reads of the whole cleared array.
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      en = 1'b1; we = 1'b0; addr = 6'(a);
      @(posedge clk);
      #1;
      check("clr_rd_data", rdata0, 32'h0);
      check("clr_rd_valid", 32'(rdv0), 32'd1);
      check("d48_lat_valid", 32'(rdv3), (a == 0) ? 32'd0 : 32'd1);
    end
    en = 1'b0;
    $display("[TB] read sweep 0..63 done");
    idle(3);

    // Full write, then partial byte-lane write.
    op(1'b1, 4'hF, 6'd5, 32'h11223344);
    check("wr5_wf", rdata0, 32'h11223344);
    check("wr5_rf", rdata1, 32'h0);
    check("wr5_nc_valid", 32'(rdv2), 32'd0);
    check("wr5_nc_hold", rdata2, 32'h0);
    idle(2);
    op(1'b1, 4'b0101, 6'd5, 32'hDEADBEEF);
    check("be_wf", rdata0, 32'h11AD33EF);
    check("be_rf", rdata1, 32'h11223344);
    check("be_nc_valid", 32'(rdv2), 32'd0);
    idle(2);
    op(1'b0, 4'h0, 6'd5, 32'h0);
    check("rd5_wf", rdata0, 32'h11AD33EF);
    check("rd5_wf_valid", 32'(rdv0), 32'd1);
    check("rd5_rf", rdata1, 32'h11AD33EF);
    check("rd5_nc", rdata2, 32'h11AD33EF);
    check("rd5_nc_valid", 32'(rdv2), 32'd1);
    check("rd5_d48_early", 32'(rdv3), 32'd0);
    @(posedge clk);
    #1;
    check("rd5_d48", rdata3, 32'h11AD33EF);
    check("rd5_d48_valid", 32'(rdv3), 32'd1);
    check("idle_wf_valid", 32'(rdv0), 32'd0);
    check("idle_wf_hold", rdata0, 32'h11AD33EF);

    // Read-during-write per mode over a cleared word.
    idle(2);
    op(1'b1, 4'hF, 6'd7, 32'hA5A5A5A5);
    check("rw_wf", rdata0, 32'hA5A5A5A5);
    check("rw_wf_valid", 32'(rdv0), 32'd1);
    check("rw_rf", rdata1, 32'h0);
    check("rw_rf_valid", 32'(rdv1), 32'd1);
    check("rw_nc_valid", 32'(rdv2), 32'd0);
    check("rw_nc_hold", rdata2, 32'h11AD33EF);
    idle(2);
    op(1'b1, 4'h0, 6'd7, 32'h12345678);
    check("be0_wf", rdata0, 32'hA5A5A5A5);
    check("be0_wf_valid", 32'(rdv0), 32'd1);
    check("be0_rf", rdata1, 32'hA5A5A5A5);
    check("be0_nc_valid", 32'(rdv2), 32'd0);
    idle(2);

    // Out-of-range on the 48-deep instance; in range on the 64-deep ones.
    op(1'b1, 4'hF, 6'd50, 32'hCAFEF00D);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 4'h0, rd_addr[i], 32'h0);
      check("seq_wf", rdata0, exp_wf[i]);
      if (i > 0) begin
        check("seq_d48", rdata3, exp_d48[i-1]);
        check("seq_d48_valid", 32'(rdv3), 32'd1);
      end
    end
    @(posedge clk);
    #1;
    check("seq_d48_last", rdata3, exp_d48[4]);

    // Asynchronous reset mid-cycle, then a reset during the clear.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_rdata", rdata0, 32'h0);
    check("arst_rdata_d48", rdata3, 32'h0);
    check("arst_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    check("clr20_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    #1;
    check("clr20_rdv", 32'(rdv0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_busy(n64, n48);
    check("reclear_len_64", 32'(n64), 32'd64);
    check("reclear_len_48", 32'(n48), 32'd48);
    idle(2);
    op(1'b0, 4'h0, 6'd5, 32'h0);
    check("reclear_rd5", rdata0, 32'h0);
    check("reclear_rd5_valid", 32'(rdv0), 32'd1);
    op(1'b0, 4'h0, 6'd50, 32'h0);
    check("reclear_rd50", rdata0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
